// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FWFT FIFO with occupancy count, level flags and sticky error flags
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       almost_full,
    output logic [DATA_W-1:0]          rdata,
    input  logic                       rd_en,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_C = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_C = (AW+1)'(AE_LVL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              wr_acc, rd_acc;

    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = wr_ptr_q == rd_ptr_q;
    assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign almost_full  = count >= AF_C;
    assign almost_empty = count <= AE_C;
    assign rdata        = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign wr_acc       = wr_en & (~full | rd_en);
    assign rd_acc       = rd_en & ~empty;

    // Next-state: flush wins over any request; a push into a full FIFO reuses the slot being popped
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            wr_ptr_d    = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_d    = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
            overflow_d  = overflow_q | (wr_en & full & ~rd_en);
            underflow_d = underflow_q | (rd_en & empty);
        end
    end

    // Pointer and error-flag registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (wr_acc && !flush && !reset) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param (DEPTH=16, AF=12, AE=2)
module tb_sync_fifo_param;
    logic       clk = 0, reset = 1, flush = 0, wr_en = 0, rd_en = 0;
    logic [7:0] wdata = 0, rdata;
    logic       full, almost_full, empty, almost_empty, overflow, underflow;
    logic [4:0] count;

    int         n_chk = 0, n_fail = 0;
    int         mc = 0;
    logic       eov = 0, eun = 0;
    logic [7:0] exp_q[$];

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LVL(12), .AE_LVL(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .wdata(wdata), .wr_en(wr_en),
        .full(full), .almost_full(almost_full), .rdata(rdata), .rd_en(rd_en),
        .empty(empty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop must present the oldest outstanding word
    always @(negedge clk) begin
        if (!reset && !flush && rd_en && !empty) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop: got %0h expected none (scoreboard empty)", rdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL pop: got %0h expected %0h at %0t", rdata, e, $time);
                end
            end
        end
    end

    task automatic check_state();
        chk("count", 32'(count), 32'(mc));
        chk("empty", 32'(empty), 32'(mc == 0));
        chk("full", 32'(full), 32'(mc == 16));
        chk("almost_full", 32'(almost_full), 32'(mc >= 12));
        chk("almost_empty", 32'(almost_empty), 32'(mc <= 2));
        chk("overflow", 32'(overflow), 32'(eov));
        chk("underflow", 32'(underflow), 32'(eun));
        if (mc > 0) chk("rdata_head", 32'(rdata), 32'(exp_q[0]));
    endtask

    task automatic clear_model();
        mc = 0; eov = 0; eun = 0;
        exp_q.delete();
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1 with state checked
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
        logic wa, ra;
        wr_en = w; wdata = d; rd_en = r; flush = f;
        if (f) clear_model();
        else begin
            wa = w && (mc < 16 || r);
            ra = r && mc > 0;
            if (w && mc == 16 && !r) eov = 1;
            if (r && mc == 0) eun = 1;
            if (wa) exp_q.push_back(d);
            mc = mc + int'(wa) - int'(ra);
        end
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0; flush = 0;
        check_state();
    endtask

    initial begin
        #1;
        check_state();
        @(posedge clk); #1;
        reset = 0;
        check_state();
        for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'hAA, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 3; k++) cyc(1, 8'(r * 3 + k + 8'h30), 0, 0);
            for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0);
        end
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0);
        cyc(1, 8'h55, 1, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
        cyc(1, 8'h77, 1, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
        cyc(1, 8'hEE, 0, 1);
        cyc(1, 8'h99, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'hD0 + i), 0, 0);
        cyc(0, 0, 1, 0);
        #2 reset = 1;
        clear_model();
        #1;
        check_state();
        @(posedge clk); #1;
        reset = 0;
        check_state();
        cyc(1, 8'h3C, 0, 0);
        cyc(0, 0, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
